clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Bank of independent, runtime-programmable clock dividers with programmable high time (duty cycle) per channel.
- Successor to the fixed-ratio divider: CHANNELS outputs, each with its own divide ratio N and high count H.
- Configuration changes are glitch-free: applied only at period boundaries. Enable/disable is also glitch-free.
- Sits in the clocking/peripheral area. Feeds slow clocks and one-cycle period ticks to timers, UART baud logic and debug blinkers.

Parameters:
- CHANNELS, 4, number of independent divider channels.
- CNT_W, 16, width of per-channel ratio, high-count and counter.
- RST_N, 2, divide ratio loaded into every channel at reset.
- RST_H, 1, high count loaded into every channel at reset.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- ch_en  in  CHANNELS  per-channel run enable, level.
- cfg_load  in  CHANNELS  per-channel one-cycle strobe; captures cfg_n/cfg_h slice i.
- cfg_n  in  CHANNELS*CNT_W  divide ratio N; slice i = bits [i*CNT_W +: CNT_W].
- cfg_h  in  CHANNELS*CNT_W  high count H, same slicing.
- clk_div  out  CHANNELS  divided outputs, registered.
- tick  out  CHANNELS  one-cycle pulse in the first cycle of each period, registered.
- cfg_pending  out  CHANNELS  1 while a loaded config awaits its boundary.

Behaviour:
- One clock; reset is synchronous and active-low. clk is the clock, rstn the reset; rstn sampled low at a rising edge resets the block.
- Reset values:
  - clk_div=0, tick=0, cfg_pending=0.
  - Counters=0, all channels in IDLE.
  - Active config = (RST_N, RST_H).
  - A reset mid-period discards the period and any pending config.
- Per-channel state:
  - Active regs n_act, h_act; pending regs n_pnd, h_pnd, pnd_v; counter cnt; FSM {IDLE, RUN, DRAIN}.
- Ratio clamp: effective N = max(N, 2). N=0 or 1 behaves as N=2.
- Output rule, while in RUN or DRAIN:
  - clk_div=1 in cycles with cnt < h_act, else 0.
  - H=0 gives constant 0; H >= N gives constant 1; tick still pulses.
  - H=N/2 with N even gives 50%. N=5, H=2 gives 2 high, 3 low.
- tick=1 exactly in cycles with cnt==0 in RUN or DRAIN.
- clk_div and tick are registered from next-state values: no combinational path from inputs to outputs.
- Period boundary = cycle with cnt == n_act_eff-1. At the next edge cnt wraps to 0.
- cfg_load[i]:
  - Captures slice i into pending and sets pnd_v.
  - A later load before the boundary overwrites the earlier one (last wins).
- Applying pending config:
  - Applied at the edge leaving a boundary cycle, at the edge leaving IDLE, or on the next edge while in IDLE.
  - On apply: n_act/h_act take the pending values, pnd_v clears.
  - If cfg_load coincides with a boundary, the newly strobed values are applied at that edge and pnd_v stays 0.
- FSM transitions:
  - IDLE: cnt=0, clk_div=0, tick=0.
  - IDLE, ch_en=1 at edge k: RUN. The cycle after edge k has cnt=0, tick=1, clk_div = (h>0), using any pending/strobed config.
  - RUN, ch_en=0: DRAIN. The current period completes unchanged.
  - DRAIN, ch_en=1 again: back to RUN, no disturbance.
  - DRAIN, boundary: IDLE at the wrap edge. No partial high pulse is ever produced.
- Counter width: cnt is CNT_W bits. cnt never exceeds n_act_eff-1. N = 2^CNT_W-1 is legal.
- Channels are fully independent; no cross-channel timing relationship is guaranteed.
- cfg_pending[i] = pnd_v of channel i.
- Implementation: generate loop over channels. Expected size 150-250 lines.

Test Plan:
- Reset:
  - Drive rstn=0 for 3 cycles with ch_en=all 1 → clk_div=0, tick=0, cfg_pending=0 throughout.
  - After release, ch0 at reset config (N=2, H=1) → clk_div toggles every cycle; tick every 2nd cycle, starting the cycle after the first enabled edge.
- Ratio/duty:
  - Load N=5, H=2 on ch1 while IDLE, then enable → repeating pattern 1,1,0,0,0; tick on each first '1'.
  - Load H=0 → constant 0. Load H=7, N=4 → constant 1; tick every 4 cycles.
  - Load N=0 and N=1 → behaves as N=2.
- Glitch-free change:
  - ch2 running N=8, H=4; strobe N=3, H=1 at cnt=2 → cfg_pending=1 for cycles cnt=3..7.
  - Old 8-cycle period completes intact; then pattern 1,0,0; cfg_pending drops at the wrap.
  - Strobe exactly at cnt=7 → new config applied at that wrap, cfg_pending never asserts.
- Last-wins load: two strobes (N=6 then N=10) in one period → next period length 10.
- Disable/drain:
  - ch3 N=6, H=3; drop ch_en at cnt=1 → remaining high/low cycles complete; IDLE after the cnt=5 wrap; clk_div=0 after.
  - Re-assert ch_en at cnt=3 during DRAIN → continuous periodic output, no extra tick.
- Reset mid-operation: assert rstn=0 at cnt=3 of an N=8 period with pending config → all outputs 0 on the next cycle; pending lost; restart uses (RST_N, RST_H).

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers with per-channel duty control.
// Config and enable changes take effect only at period boundaries, so outputs never glitch.
module clk_div_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned RST_N    = 2,
  parameter int unsigned RST_H    = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       cfg_load,
  input  logic [CHANNELS*CNT_W-1:0] cfg_n,
  input  logic [CHANNELS*CNT_W-1:0] cfg_h,
  output logic [CHANNELS-1:0]       clk_div,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       cfg_pending
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] n_act, h_act, n_act_nx, h_act_nx;
    logic [CNT_W-1:0] n_pnd, h_pnd, n_pnd_nx, h_pnd_nx;
    logic [CNT_W-1:0] n_src, h_src, last;
    logic             pnd_v, pnd_v_nx, src_v;
    logic             boundary, apply;
    logic             div_q, tick_q;

    // Next-state: config apply/capture, then counter and run state
    always_comb begin
      n_act_nx = n_act;
      h_act_nx = h_act;
      n_pnd_nx = n_pnd;
      h_pnd_nx = h_pnd;
      pnd_v_nx = pnd_v;
      st_nx    = st;
      cnt_nx   = cnt;

      // A strobe in the same cycle supersedes whatever is already pending
      n_src = cfg_load[i] ? cfg_n[i*CNT_W +: CNT_W] : n_pnd;
      h_src = cfg_load[i] ? cfg_h[i*CNT_W +: CNT_W] : h_pnd;
      src_v = cfg_load[i] | pnd_v;

      // Ratios of 0 and 1 are clamped to 2, so the last count is at least 1
      last     = (n_act < CNT_W'(2)) ? CNT_W'(1) : n_act - CNT_W'(1);
      boundary = (st != IDLE) && (cnt == last);
      apply    = (st == IDLE) || boundary;

      if (apply && src_v) begin
        n_act_nx = n_src;
        h_act_nx = h_src;
        pnd_v_nx = 1'b0;
      end else if (cfg_load[i]) begin
        n_pnd_nx = n_src;
        h_pnd_nx = h_src;
        pnd_v_nx = 1'b1;
      end

      case (st)
        IDLE: begin
          cnt_nx = '0;
          st_nx  = ch_en[i] ? RUN : IDLE;
        end
        RUN, DRAIN: begin
          if (boundary) begin
            cnt_nx = '0;
            st_nx  = ch_en[i] ? RUN : IDLE;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
            st_nx  = ch_en[i] ? RUN : DRAIN;
          end
        end
        default: begin
          cnt_nx = '0;
          st_nx  = IDLE;
        end
      endcase
    end

    // State and outputs registered from next-state values
    always_ff @(posedge clk) begin
      if (!rstn) begin
        st     <= IDLE;
        cnt    <= '0;
        n_act  <= CNT_W'(RST_N);
        h_act  <= CNT_W'(RST_H);
        n_pnd  <= '0;
        h_pnd  <= '0;
        pnd_v  <= 1'b0;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        st     <= st_nx;
        cnt    <= cnt_nx;
        n_act  <= n_act_nx;
        h_act  <= h_act_nx;
        n_pnd  <= n_pnd_nx;
        h_pnd  <= h_pnd_nx;
        pnd_v  <= pnd_v_nx;
        div_q  <= (st_nx != IDLE) && (cnt_nx < h_act_nx);
        tick_q <= (st_nx != IDLE) && (cnt_nx == '0);
      end
    end

    assign clk_div[i]     = div_q;
    assign tick[i]        = tick_q;
    assign cfg_pending[i] = pnd_v;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: table vectors, directed corner sequences,
// and randomized traffic against a period-level reference model.
module tb_clk_div_bank;
  localparam int unsigned CH = 4;
  localparam int unsigned W  = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CH-1:0] ch_en, cfg_load;
  logic [CH*W-1:0] cfg_n, cfg_h;
  logic [CH-1:0] clk_div, tick, cfg_pending;

  int total = 0;
  int bad   = 0;

  // Reference model: per channel, whether a period is in progress and the position in it
  bit busy [CH];
  int pos  [CH];
  int mn   [CH];
  int mh   [CH];
  int pn   [CH];
  int ph   [CH];
  bit pv   [CH];

  typedef struct {
    bit en; bit ld; int n; int h;
    bit div; bit tk; bit pd;
  } vec_t;
  vec_t tv [31];

  clk_div_bank #(.CHANNELS(CH), .CNT_W(W), .RST_N(2), .RST_H(1)) dut (
    .clk(clk), .rstn(rstn), .ch_en(ch_en), .cfg_load(cfg_load),
    .cfg_n(cfg_n), .cfg_h(cfg_h),
    .clk_div(clk_div), .tick(tick), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      busy[i] = 0; pos[i] = 0; mn[i] = 2; mh[i] = 1; pn[i] = 0; ph[i] = 0; pv[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs present before the edge
  task automatic model_edge();
    int sn, sh, eff;
    bit valid, bnd;
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      sn    = cfg_load[i] ? int'(cfg_n[i*W +: W]) : pn[i];
      sh    = cfg_load[i] ? int'(cfg_h[i*W +: W]) : ph[i];
      valid = cfg_load[i] || pv[i];
      eff   = (mn[i] < 2) ? 2 : mn[i];
      bnd   = busy[i] && (pos[i] == eff - 1);
      if ((!busy[i] || bnd) && valid) begin
        mn[i] = sn; mh[i] = sh; pv[i] = 0;
      end else if (cfg_load[i]) begin
        pn[i] = sn; ph[i] = sh; pv[i] = 1;
      end
      if (!busy[i] || bnd) begin
        busy[i] = ch_en[i];
        pos[i]  = 0;
      end else begin
        pos[i]++;
      end
    end
  endtask

  // Advance one cycle, compare all channels to the model, then drop strobes
  task automatic step();
    logic [CH-1:0] e_div, e_tk, e_pd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      e_div[i] = busy[i] && (pos[i] < mh[i]);
      e_tk[i]  = busy[i] && (pos[i] == 0);
      e_pd[i]  = pv[i];
    end
    check("model_clk_div", 64'(clk_div), 64'(e_div));
    check("model_tick", 64'(tick), 64'(e_tk));
    check("model_cfg_pending", 64'(cfg_pending), 64'(e_pd));
    cfg_load = '0;
  endtask

  task automatic load(input int ch, input int n, input int h);
    cfg_load[ch]     = 1'b1;
    cfg_n[ch*W +: W] = W'(n);
    cfg_h[ch*W +: W] = W'(h);
  endtask

  initial begin
    int cyc;
    bit found;
    rstn = 1'b0; ch_en = '0; cfg_load = '0; cfg_n = '0; cfg_h = '0;
    model_reset();

    tv[0]  = '{1'b0, 1'b1, 5, 2, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 5, 0, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
    tv[12] = '{1'b1, 1'b1, 4, 7, 1'b0, 1'b0, 1'b1};
    tv[13] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
    tv[14] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
    tv[15] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
    tv[16] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tv[17] = '{1'b1, 1'b1, 1, 1, 1'b1, 1'b0, 1'b1};
    tv[18] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1};
    tv[19] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1};
    tv[20] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tv[21] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[22] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tv[23] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[24] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[25] = '{1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0};
    tv[26] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tv[27] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[28] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    tv[29] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tv[30] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};

    // Reset held with every channel enabled
    ch_en = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_outputs", {clk_div, tick, cfg_pending}, 64'd0);
    end

    // Channel 0 at reset config: toggles each cycle, tick every second cycle
    rstn = 1'b1; ch_en = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rst_cfg_div", 64'(clk_div[0]), 64'((k % 2) == 0));
      check("rst_cfg_tick", 64'(tick[0]), 64'((k % 2) == 0));
    end
    ch_en = '0;
    repeat (3) step();

    // Channel 1 ratio/duty/clamp vectors
    for (int k = 0; k < 31; k++) begin
      ch_en[1] = tv[k].en;
      if (tv[k].ld) load(1, tv[k].n, tv[k].h);
      step();
      check($sformatf("vec%0d_div", k), 64'(clk_div[1]), 64'(tv[k].div));
      check($sformatf("vec%0d_tick", k), 64'(tick[1]), 64'(tv[k].tk));
      check($sformatf("vec%0d_pend", k), 64'(cfg_pending[1]), 64'(tv[k].pd));
    end

    // Channel 2: mid-period strobe waits for the boundary
    ch_en[2] = 1'b1; load(2, 8, 4);
    step();
    repeat (2) step();
    load(2, 3, 1);
    for (int k = 3; k <= 7; k++) begin
      step();
      check("glitch_pend_held", 64'(cfg_pending[2]), 64'd1);
    end
    step();
    check("glitch_pend_drop", 64'(cfg_pending[2]), 64'd0);
    check("glitch_new_tick", 64'(tick[2]), 64'd1);
    repeat (2) step();
    load(2, 8, 4);
    step();
    check("boundary_load_pend", 64'(cfg_pending[2]), 64'd0);
    repeat (7) step();
    load(2, 3, 1);
    step();
    check("boundary7_load_pend", 64'(cfg_pending[2]), 64'd0);
    repeat (6) step();

    // Channel 3: drain after enable drop, then re-enable during drain
    ch_en[3] = 1'b1; load(3, 6, 3);
    step();
    step();
    ch_en[3] = 1'b0;
    repeat (4) step();
    step();
    check("drain_idle_div", 64'(clk_div[3]), 64'd0);
    check("drain_idle_tick", 64'(tick[3]), 64'd0);
    ch_en[3] = 1'b1;
    step();
    step();
    ch_en[3] = 1'b0;
    repeat (2) step();
    ch_en[3] = 1'b1;
    repeat (10) step();

    // Last-wins: two strobes in one period, the later ratio defines the next period
    load(3, 6, 3);
    step();
    load(3, 10, 5);
    step();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      found = tick[3];
    end
    if (!found) check("lastwins_tick_timeout", 64'd0, 64'd1);
    cyc = 0;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      cyc++;
      found = tick[3];
    end
    check("lastwins_period", 64'(cyc), 64'd10);

    // Reset mid-period with a pending config on channel 2
    ch_en = 4'b0100;
    load(2, 8, 4);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      found = busy[2] && (mn[2] == 8) && (pos[2] == 1) && !pv[2];
    end
    if (!found) check("midrst_setup_timeout", 64'd0, 64'd1);
    load(2, 5, 2);
    step();
    step();
    check("midrst_pend_before", 64'(cfg_pending[2]), 64'd1);
    rstn = 1'b0;
    step();
    check("midrst_outputs", {clk_div, tick, cfg_pending}, 64'd0);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst_restart_div", 64'(clk_div[2]), 64'((k % 2) == 0));
      check("midrst_restart_pend", 64'(cfg_pending[2]), 64'd0);
    end

    // Randomized traffic against the model
    ch_en = '1;
    for (int k = 0; k < 1200; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
        if ($urandom_range(0, 11) == 0)
          load(i, int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
      end
      rstn = ($urandom_range(0, 299) != 0);
      step();
    end
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
